apb_wait_mem_slave: RTL
=======================

Name: apb_wait_mem_slave

Overview:
Parametrised APB slave with a register-array memory. It generalises the fixed 8x8 combinational slave into a clocked FSM slave with:
- configurable data width, address width and depth;
- programmable wait states;
- out-of-range error reporting on o_PSLVERR.

It sits behind the APB master/decoder as a selectable peripheral. One i_PSEL per instance.

Parameters:
DATA_WIDTH, 32, width of i_PWDATA/o_PRDATA; multiple of 8.
ADDR_WIDTH, 8, width of i_PADDR; i_PADDR is a word index.
DEPTH, 16, number of memory words; 1 <= DEPTH <= 2**ADDR_WIDTH.
WAIT_STATES, 0, access-phase wait cycles before o_PREADY; range 0..15.

Ports:
i_PCLK  in  1  APB clock; all state updates on rising edge.
i_PRESETn  in  1  asynchronous active-low reset.
i_PSEL  in  1  slave select.
i_PENABLE  in  1  access-phase indicator.
i_PWRITE  in  1  1 = write, 0 = read.
i_PADDR  in  ADDR_WIDTH  word address.
i_PWDATA  in  DATA_WIDTH  write data.
i_PSTRB  in  DATA_WIDTH/8  byte-lane strobes; present only with APB_PSTRB_EN.
o_PRDATA  out  DATA_WIDTH  read data; registered.
o_PREADY  out  1  transfer-complete; registered.
o_PSLVERR  out  1  error flag, valid only with o_PREADY; registered.

Behaviour:
Clocking and reset:
- One clock, i_PCLK. Reset i_PRESETn is asynchronous, active-low.
- While reset is low: state = IDLE, wait counter = 0, o_PREADY = 0, o_PSLVERR = 0, o_PRDATA = 0, all memory words = 0.
- Reset asserted mid-transfer aborts the transfer. A pending write is not committed.

FSM states: IDLE, ACCESS.
- IDLE, i_PSEL=1 and i_PENABLE=0 at a clock edge (setup phase):
  - capture address, direction and write data; go to ACCESS;
  - load counter with WAIT_STATES.
  - If WAIT_STATES=0: at this same edge set o_PREADY=1. For a read, also load o_PRDATA = mem[addr], or 0 on error. Set o_PSLVERR = (addr >= DEPTH).
- IDLE, i_PENABLE=1 without a preceding setup: ignored. Stay IDLE, o_PREADY stays 0.
- ACCESS with counter > 1: decrement; o_PREADY stays 0.
- ACCESS with counter = 1: decrement to 0; set o_PREADY, o_PRDATA and o_PSLVERR as above.
- ACCESS with i_PSEL & i_PENABLE & o_PREADY at an edge (completion):
  - a write with addr < DEPTH commits to memory at this edge;
  - clear o_PREADY, o_PSLVERR and o_PRDATA to 0; go to IDLE.
- ACCESS with i_PSEL dropping before completion (protocol abort): go to IDLE, clear outputs, no memory update.

Timing and data rules:
- o_PREADY is high in access cycle WAIT_STATES+1. Every transfer takes 2+WAIT_STATES cycles.
- Back-to-back transfers always re-enter through a setup phase.
- o_PRDATA is nonzero only while o_PREADY=1 on a successful read.
- Error (addr >= DEPTH): write is discarded, read returns 0, o_PSLVERR=1 alongside o_PREADY.
- Addresses are compared at full ADDR_WIDTH. No wrap-around or aliasing.
- Read following a write to the same address returns the new data: the write commits at its completion edge, before the read's setup edge.

Optional Feature:
APB_PSTRB_EN
- Defined: i_PSTRB port exists. A valid write updates only byte lanes with i_PSTRB[k]=1. All-zero strobes leave the word unchanged but still complete with o_PREADY=1, o_PSLVERR=0. Reads ignore i_PSTRB.
- Undefined: no i_PSTRB port. Every valid write updates the full word.

Test Plan:
- Reset mid-write: WAIT_STATES=3, write 0xDEADBEEF to addr 2, pulse i_PRESETn low in the 2nd access cycle -> outputs 0 immediately; a later read of addr 2 returns 0x00000000.
- WAIT_STATES=0: write 0xA5A5A5A5 to addr 5, then read addr 5 -> o_PREADY high in first access cycle of each; read returns 0xA5A5A5A5, o_PSLVERR=0; each transfer takes 2 cycles.
- WAIT_STATES=3: read addr 0 after reset -> o_PREADY low for 3 access cycles, high on the 4th; o_PRDATA=0; o_PRDATA is 0 in all other cycles.
- DEPTH=16, write 0x12345678 to addr 16 -> o_PREADY=1 with o_PSLVERR=1. A following read of addr 16 returns 0 with o_PSLVERR=1. Read of addr 0 still returns its prior value.
- Protocol abort: setup a write to addr 3, drop i_PSEL in access with WAIT_STATES=2 -> FSM returns IDLE, no o_PREADY, addr 3 unchanged.
- APB_PSTRB_EN: mem[1]=0x11223344, write 0xAABBCCDD with i_PSTRB=4'b0101 -> read addr 1 returns 0x11BB33DD.

Source files
------------

// File: rtl/apb_wait_mem_slave.sv
// APB slave backed by a register-array memory, with programmable wait states and out-of-range PSLVERR.
// Optional byte-lane write strobes on i_PSTRB are enabled by defining APB_PSTRB_EN.
module apb_wait_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    i_PCLK,
  input  logic                    i_PRESETn,
  input  logic                    i_PSEL,
  input  logic                    i_PENABLE,
  input  logic                    i_PWRITE,
  input  logic [ADDR_WIDTH-1:0]   i_PADDR,
  input  logic [DATA_WIDTH-1:0]   i_PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] i_PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   o_PRDATA,
  output logic                    o_PREADY,
  output logic                    o_PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WAIT_C  = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              waitCnt_q, waitCnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [STRB_W-1:0]       strbIn;
  logic [ADDR_WIDTH-1:0]   lookAddr;
  logic [IDX_W-1:0]        lookIdx;
  logic                    lookErr;
  logic                    lookWrite;
  logic [DATA_WIDTH-1:0]   lookData;
  logic [IDX_W-1:0]        wrIdx;
  logic                    memWe;

`ifdef APB_PSTRB_EN
  assign strbIn = i_PSTRB;
`else
  assign strbIn = '1;
`endif

  // In IDLE the response is built from the live bus (zero-wait case), otherwise from the captured request.
  always_comb begin
    lookAddr  = (state_q == IDLE) ? i_PADDR : addr_q;
    lookWrite = (state_q == IDLE) ? i_PWRITE : write_q;
    lookErr   = ({1'b0, lookAddr} >= DEPTH_C);
    lookIdx   = lookAddr[IDX_W-1:0];
    lookData  = '0;
    if (!lookErr) begin
      lookData = mem_q[lookIdx];
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    memWe     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_PSEL && !i_PENABLE) begin
          state_d   = ACCESS;
          waitCnt_d = WAIT_C;
          addr_d    = i_PADDR;
          write_d   = i_PWRITE;
          wdata_d   = i_PWDATA;
          strb_d    = strbIn;
          if (WAIT_C == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = lookErr;
            prdata_d  = lookWrite ? '0 : lookData;
          end
        end
      end

      ACCESS: begin
        if (!i_PSEL) begin
          state_d   = IDLE;
          waitCnt_d = 4'd0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (i_PENABLE && pready_q) begin
          memWe     = write_q && !lookErr;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (waitCnt_q > 4'd1) begin
          waitCnt_d = waitCnt_q - 4'd1;
        end else if (waitCnt_q == 4'd1) begin
          waitCnt_d = 4'd0;
          pready_d  = 1'b1;
          pslverr_d = lookErr;
          prdata_d  = lookWrite ? '0 : lookData;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q   <= IDLE;
      waitCnt_q <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign wrIdx = addr_q[IDX_W-1:0];

  // Writes land only on the completion edge, so an aborted or reset transfer never touches memory.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (memWe) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (strb_q[k]) begin
          mem_q[wrIdx][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign o_PRDATA  = prdata_q;
  assign o_PREADY  = pready_q;
  assign o_PSLVERR = pslverr_q;

endmodule
